// File: rtl/rx_frame_buffer.sv
// -----------------------------------------------------------------------------
// rx_frame_buffer
//
// Captures one image frame from a byte-serial receiver into an on-chip pixel
// memory. A frame is a start-of-frame marker (SOF_BYTE) followed by
// TOTAL_PIXELS pixel bytes. When checksum support is built in, one more byte
// follows: the XOR of all pixel bytes. A completed frame is held
// (frame_ready) until the consumer releases it with frame_ack. While a frame
// is held, any further byte is dropped and reported. The pixel memory can be
// read at any time through a registered, read-first port.
//
// Build option:
//   RX_FRAME_CHECKSUM_EN - when defined, adds the CHK state and the checksum
//                          register, and drives err_chk. When undefined, the
//                          last pixel goes straight to DONE and err_chk is 0.
//
// Ports:
//   clk          clock; all logic on the rising edge
//   reset        synchronous, active-high reset
//   rx_data      incoming byte from the serial receiver
//   rx_valid     one-cycle strobe qualifying rx_data
//   re           read enable for the pixel read port
//   rd_addr      pixel read address
//   rd_data      registered read data, valid one cycle after re
//   frame_ack    consumer releases the completed frame
//   frame_ready  level; a complete frame is held in memory
//   busy         high while a frame is being received (DATA or CHK)
//   err_timeout  one-cycle pulse when a frame is aborted by an idle gap
//   err_overrun  one-cycle pulse when a byte is dropped while holding a frame
//   err_chk      one-cycle pulse on checksum mismatch
// -----------------------------------------------------------------------------
module rx_frame_buffer #(
   parameter int                    DATA_WIDTH     = 8,
   parameter int                    TOTAL_PIXELS   = 9600,
   parameter int                    ADDR_WIDTH     = $clog2(TOTAL_PIXELS),
   parameter logic [DATA_WIDTH-1:0] SOF_BYTE       = DATA_WIDTH'(8'hAA),
   parameter int                    TIMEOUT_CYCLES = 100000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_valid,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  frame_ack,
   output logic                  frame_ready,
   output logic                  busy,
   output logic                  err_timeout,
   output logic                  err_overrun,
   output logic                  err_chk
);

   // The gap counter only has to reach TIMEOUT_CYCLES-1.
   localparam int GAP_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [GAP_WIDTH-1:0]  GAP_LAST  = GAP_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(TOTAL_PIXELS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
`ifdef RX_FRAME_CHECKSUM_EN
      CHK  = 2'd2,
`endif
      DONE = 2'd3
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [ADDR_WIDTH-1:0]   wr_addr_next;
   logic [GAP_WIDTH-1:0]    gap;
   logic [GAP_WIDTH-1:0]    gap_next;
   logic                    wr_en;
   logic                    timeout_next;
   logic                    overrun_next;

   logic [DATA_WIDTH-1:0]   mem [TOTAL_PIXELS];

`ifdef RX_FRAME_CHECKSUM_EN
   logic [DATA_WIDTH-1:0]   checksum;
   logic [DATA_WIDTH-1:0]   checksum_next;
   logic                    chk_err_next;
`endif

   assign frame_ready = (state == DONE);
`ifdef RX_FRAME_CHECKSUM_EN
   assign busy = (state == DATA) || (state == CHK);
`else
   assign busy = (state == DATA);
`endif

   // Next-state and datapath control
   always_comb begin
      state_next    = state;
      wr_addr_next  = wr_addr;
      gap_next      = gap;
      wr_en         = 1'b0;
      timeout_next  = 1'b0;
      overrun_next  = 1'b0;
`ifdef RX_FRAME_CHECKSUM_EN
      checksum_next = checksum;
      chk_err_next  = 1'b0;
`endif
      case (state)
         IDLE: begin
            gap_next = '0;
            if (rx_valid && (rx_data == SOF_BYTE)) begin
               state_next    = DATA;
               wr_addr_next  = '0;
`ifdef RX_FRAME_CHECKSUM_EN
               checksum_next = '0;
`endif
            end
         end

         DATA: begin
            // A byte arriving on the timeout cycle wins: it is stored and
            // the gap counter restarts.
            if (rx_valid) begin
               wr_en         = 1'b1;
               gap_next      = '0;
`ifdef RX_FRAME_CHECKSUM_EN
               checksum_next = checksum ^ rx_data;
`endif
               if (wr_addr == ADDR_LAST) begin
                  wr_addr_next = '0;
`ifdef RX_FRAME_CHECKSUM_EN
                  state_next   = CHK;
`else
                  state_next   = DONE;
`endif
               end else begin
                  wr_addr_next = wr_addr + 1'b1;
               end
            end else if (gap == GAP_LAST) begin
               state_next   = IDLE;
               timeout_next = 1'b1;
               gap_next     = '0;
            end else begin
               gap_next = gap + 1'b1;
            end
         end

`ifdef RX_FRAME_CHECKSUM_EN
         CHK: begin
            if (rx_valid) begin
               gap_next = '0;
               if (rx_data == checksum) begin
                  state_next = DONE;
               end else begin
                  state_next   = IDLE;
                  chk_err_next = 1'b1;
               end
            end else if (gap == GAP_LAST) begin
               state_next   = IDLE;
               timeout_next = 1'b1;
               gap_next     = '0;
            end else begin
               gap_next = gap + 1'b1;
            end
         end
`endif

         DONE: begin
            gap_next = '0;
            if (rx_valid) begin
               overrun_next = 1'b1;
            end
            if (frame_ack) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and control registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         wr_addr     <= '0;
         gap         <= '0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         state       <= state_next;
         wr_addr     <= wr_addr_next;
         gap         <= gap_next;
         err_timeout <= timeout_next;
         err_overrun <= overrun_next;
      end
   end

`ifdef RX_FRAME_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         checksum <= '0;
         err_chk  <= 1'b0;
      end else begin
         checksum <= checksum_next;
         err_chk  <= chk_err_next;
      end
   end
`else
   assign err_chk = 1'b0;
`endif

   // Pixel memory write port. A byte arriving during reset is not stored,
   // so a reset mid-frame leaves memory exactly as it was.
   always_ff @(posedge clk) begin
      if (wr_en && !reset) begin
         mem[wr_addr] <= rx_data;
      end
   end

   // Registered read port; the nonblocking write above makes a same-address
   // read return the old contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data <= '0;
      end else if (re) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: tb/tb_rx_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_rx_frame_buffer
//
// Bench for rx_frame_buffer with TOTAL_PIXELS=4 and TIMEOUT_CYCLES=16.
// A frame-level reference model (mode, pixel count, idle-cycle count, XOR,
// memory image) predicts every output after each clock edge. Directed frames
// cover the documented scenarios; a randomized phase then mixes markers,
// pixels, idle bursts, acks, reads and resets. Honours RX_FRAME_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_rx_frame_buffer;

   localparam int P   = 4;
   localparam int TMO = 16;
`ifdef RX_FRAME_CHECKSUM_EN
   localparam bit CK_EN = 1'b1;
`else
   localparam bit CK_EN = 1'b0;
`endif

   localparam int M_IDLE    = 0;
   localparam int M_COLLECT = 1;
   localparam int M_AWAIT   = 2;
   localparam int M_HOLD    = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       re;
   logic [1:0] rd_addr;
   logic [7:0] rd_data;
   logic       frame_ack;
   logic       frame_ready;
   logic       busy;
   logic       err_timeout;
   logic       err_overrun;
   logic       err_chk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int         m_mode;
   int         m_cnt;
   int         m_idle;
   logic [7:0] m_xor;
   logic [7:0] m_mem [P];
   bit         m_known [P];
   logic [7:0] e_rd;
   bit         e_rd_known;
   bit         e_to, e_ov, e_ck;
   bit         m_live;

   always #5 clk = ~clk;

   rx_frame_buffer #(
      .DATA_WIDTH    (8),
      .TOTAL_PIXELS  (P),
      .SOF_BYTE      (8'hAA),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .re         (re),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .frame_ack  (frame_ack),
      .frame_ready(frame_ready),
      .busy       (busy),
      .err_timeout(err_timeout),
      .err_overrun(err_overrun),
      .err_chk    (err_chk)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advances the model by one clock edge using the inputs sampled there.
   task automatic model_step(input logic v, input logic [7:0] d, input logic r,
                             input logic [1:0] a, input logic k, input logic rs);
      e_to = 1'b0;
      e_ov = 1'b0;
      e_ck = 1'b0;
      if (rs) begin
         m_live     = 1'b1;
         m_mode     = M_IDLE;
         m_cnt      = 0;
         m_idle     = 0;
         m_xor      = 8'h00;
         e_rd       = 8'h00;
         e_rd_known = 1'b1;
         return;
      end
      if (r) begin
         e_rd       = m_mem[a];
         e_rd_known = m_known[a];
      end
      case (m_mode)
         M_IDLE: begin
            if (v && d == 8'hAA) begin
               m_mode = M_COLLECT;
               m_cnt  = 0;
               m_idle = 0;
               m_xor  = 8'h00;
            end
         end
         M_COLLECT, M_AWAIT: begin
            if (v) begin
               m_idle = 0;
               if (m_mode == M_COLLECT) begin
                  m_mem[m_cnt]   = d;
                  m_known[m_cnt] = 1'b1;
                  m_xor          = m_xor ^ d;
                  m_cnt++;
                  if (m_cnt == P) m_mode = CK_EN ? M_AWAIT : M_HOLD;
               end else if (d == m_xor) begin
                  m_mode = M_HOLD;
               end else begin
                  m_mode = M_IDLE;
                  e_ck   = 1'b1;
               end
            end else begin
               m_idle++;
               if (m_idle == TMO) begin
                  m_mode = M_IDLE;
                  e_to   = 1'b1;
               end
            end
         end
         default: begin
            if (v) e_ov = 1'b1;
            if (k) m_mode = M_IDLE;
         end
      endcase
   endtask

   task automatic compare_all();
      if (!m_live) return;
      check("frame_ready", 32'(frame_ready), 32'(m_mode == M_HOLD));
      check("busy", 32'(busy), 32'(m_mode == M_COLLECT || m_mode == M_AWAIT));
      check("err_timeout", 32'(err_timeout), 32'(e_to));
      check("err_overrun", 32'(err_overrun), 32'(e_ov));
      check("err_chk", 32'(err_chk), 32'(e_ck));
      if (e_rd_known) check("rd_data", 32'(rd_data), 32'(e_rd));
   endtask

   task automatic cycle(input logic v, input logic [7:0] d, input logic r,
                        input logic [1:0] a, input logic k, input logic rs);
      rx_valid  = v;
      rx_data   = d;
      re        = r;
      rd_addr   = a;
      frame_ack = k;
      reset     = rs;
      @(posedge clk);
      model_step(v, d, r, a, k, rs);
      #1;
      compare_all();
   endtask

   task automatic send(input logic [7:0] b);
      cycle(1'b1, b, 1'b0, 2'd0, 1'b0, 1'b0);
   endtask

   task automatic idle();
      cycle(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
   endtask

   task automatic rd(input logic [1:0] a);
      cycle(1'b0, 8'h00, 1'b1, a, 1'b0, 1'b0);
   endtask

   initial begin
      m_live     = 1'b0;
      m_mode     = M_IDLE;
      m_cnt      = 0;
      m_idle     = 0;
      m_xor      = 8'h00;
      e_rd       = 8'h00;
      e_rd_known = 1'b0;
      for (int i = 0; i < P; i++) begin
         m_known[i] = 1'b0;
         m_mem[i]   = 8'h00;
      end

      // Reset state
      cycle(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);
      cycle(1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 1'b1);
      check("rst_ready", 32'(frame_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rd", 32'(rd_data), 32'd0);

      // Garbage before marker, then a good frame
      send(8'h55);
      check("pre_sof_busy", 32'(busy), 32'd0);
      send(8'hAA);
      check("sof_busy", 32'(busy), 32'd1);
      for (int i = 1; i <= 4; i++) send(8'(i));
`ifdef RX_FRAME_CHECKSUM_EN
      check("chk_wait_ready", 32'(frame_ready), 32'd0);
      send(8'h04);
`endif
      check("frame_ready", 32'(frame_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         rd(2'(i));
         check("rd_frame", 32'(rd_data), 32'(i + 1));
      end

      // Overrun while holding a frame, then release
      send(8'h77);
      check("ovr_pulse", 32'(err_overrun), 32'd1);
      idle();
      check("ovr_end", 32'(err_overrun), 32'd0);
      rd(2'd0);
      check("ovr_mem", 32'(rd_data), 32'h01);
      cycle(1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0);
      check("ack_ready", 32'(frame_ready), 32'd0);
      cycle(1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0);

`ifdef RX_FRAME_CHECKSUM_EN
      // Bad checksum
      send(8'hAA);
      for (int i = 1; i <= 4; i++) send(8'(i));
      send(8'hFF);
      check("chk_err", 32'(err_chk), 32'd1);
      check("chk_ready", 32'(frame_ready), 32'd0);
      check("chk_busy", 32'(busy), 32'd0);
      idle();
`endif

      // Idle-gap timeout, then a fresh frame completes
      send(8'hAA);
      send(8'h10);
      send(8'h20);
      for (int i = 0; i < TMO - 1; i++) idle();
      check("tmo_early", 32'(err_timeout), 32'd0);
      check("tmo_busy_early", 32'(busy), 32'd1);
      idle();
      check("tmo_pulse", 32'(err_timeout), 32'd1);
      check("tmo_busy", 32'(busy), 32'd0);
      send(8'hAA);
      send(8'h05);
      send(8'h06);
      send(8'h07);
      send(8'h08);
`ifdef RX_FRAME_CHECKSUM_EN
      send(8'h0C);
`endif
      check("refill_ready", 32'(frame_ready), 32'd1);
      cycle(1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0);

      // Reset mid-frame
      send(8'hAA);
      send(8'h01);
      cycle(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b1);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_errs", 32'({err_timeout, err_overrun, err_chk}), 32'd0);
      rd(2'd0);
      check("rst_mid_mem", 32'(rd_data), 32'h01);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int         sel;
         logic [7:0] b;
         if ($urandom_range(0, 99) < 3) begin
            int len = int'($urandom_range(5, 20));
            for (int j = 0; j < len; j++)
               cycle(1'b0, 8'h00, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0, 1'b0);
         end else begin
            sel = int'($urandom_range(0, 9));
            if (sel < 2)      b = 8'hAA;
            else if (sel < 4) b = m_xor;
            else              b = 8'($urandom_range(0, 255));
            cycle(1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 199) == 0));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rx_frame_buffer.md
RX_FRAME_BUFFER -- requirements
Module: rx_frame_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, pixel and byte width.
REQ-002 Parameter TOTAL_PIXELS, default 9600, pixels per frame.
REQ-003 Parameter ADDR_WIDTH, default $clog2(TOTAL_PIXELS), read address width.
REQ-004 Parameter SOF_BYTE, default 8'hAA, start-of-frame marker.
REQ-005 Parameter TIMEOUT_CYCLES, default 100000, maximum idle gap between bytes inside a frame.
REQ-006 clk  input  1  clock; all logic on the rising edge.
REQ-007 reset  input  1  reset, synchronous, active-high.
REQ-008 rx_data  input  DATA_WIDTH  incoming byte from the serial receiver.
REQ-009 rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle.
REQ-010 re  input  1  read enable for the pixel read port.
REQ-011 rd_addr  input  ADDR_WIDTH  pixel read address.
REQ-012 rd_data  output  DATA_WIDTH  registered read data.
REQ-013 frame_ack  input  1  consumer releases the completed frame.
REQ-014 frame_ready  output  1  level; a complete frame is held in memory.
REQ-015 busy  output  1  high while in DATA or CHK.
REQ-016 err_timeout  output  1  one-cycle pulse on an aborted frame.
REQ-017 err_overrun  output  1  one-cycle pulse when a byte is dropped in DONE.
REQ-018 err_chk  output  1  one-cycle pulse on checksum mismatch; tied 0 when checksum is compiled out.

Function
REQ-019 Memory SHALL be TOTAL_PIXELS x DATA_WIDTH with one write port (internal) and one read port.
REQ-020 FSM states SHALL be IDLE, DATA, CHK (checksum build only), DONE.
REQ-021 IDLE: rx_valid with rx_data==SOF_BYTE -> DATA with wr_addr=0 and checksum=0; other bytes discarded.
REQ-022 DATA: each rx_valid writes rx_data to mem[wr_addr] and wr_addr increments; the byte written at wr_addr==TOTAL_PIXELS-1 -> CHK (checksum build) or DONE (otherwise).
REQ-023 In DATA, a byte equal to SOF_BYTE SHALL be stored as pixel data, not treated as a marker.
REQ-024 CHK: next rx_valid is compared with the XOR of all frame pixels; match -> DONE, mismatch -> IDLE with err_chk pulse.
REQ-025 DONE: frame_ready=1; frame_ack -> IDLE next cycle, frame_ready low in that cycle; frame_ack outside DONE is ignored.
REQ-026 DONE: rx_valid SHALL not write memory and SHALL pulse err_overrun in the following cycle.
REQ-027 Gap counter SHALL clear on each rx_valid in DATA/CHK; reaching TIMEOUT_CYCLES-1 -> IDLE with err_timeout pulse; counter inactive in IDLE/DONE.
REQ-028 If rx_valid and the timeout fire in the same cycle, the byte SHALL take priority and the counter clears.
REQ-029 Read: re=1 SHALL load rd_data<=mem[rd_addr] with 1-cycle latency; re=0 holds rd_data; reads are legal in every state.
REQ-030 Reading an address during DATA before it is written SHALL return the previous frame's contents.
REQ-031 Simultaneous write and read at the same address SHALL return old data (read-first).

Reset
REQ-032 Reset SHALL force IDLE, wr_addr=0, gap counter=0, checksum=0, rd_data=0, and frame_ready/busy/err_* = 0.
REQ-033 Reset mid-frame SHALL abort without an error pulse; memory contents are not cleared.

Configuration
REQ-034 Macro RX_FRAME_CHECKSUM_EN defined: CHK state present; one trailing XOR byte required after the pixels; err_chk is active.
REQ-035 RX_FRAME_CHECKSUM_EN undefined: no CHK state or checksum register; DATA -> DONE after the last pixel; err_chk is constant 0.

Verification (TOTAL_PIXELS=4, TIMEOUT_CYCLES=16)
REQ-036 Stream 0x55, AA, 01, 02, 03, 04, [04 if checksum] -> 0x55 ignored; frame_ready=1; reads of addr 0..3 return 01..04 one cycle after re.
REQ-037 Checksum build: AA, 01, 02, 03, 04, FF -> err_chk pulse, frame_ready stays 0, FSM returns to IDLE.
REQ-038 AA, 10, 20, then no bytes for 16 cycles -> err_timeout pulse, busy=0; a new AA frame then completes normally.
REQ-039 Frame complete, extra byte 0x77 before frame_ack -> err_overrun pulse, mem unchanged; frame_ack -> frame_ready=0 the next cycle.
REQ-040 Reset asserted after AA, 01 -> IDLE, no error pulses, addr 0 still reads 01.
